irrigation_countdown_timer: RTL and testbench



---
 rtl/irrigation_countdown_timer_pkg.sv | 23 ++
 rtl/irrigation_countdown_timer_if.sv | 35 +++
 rtl/irrigation_countdown_timer_bcd_down_digit.sv | 31 +++
 rtl/irrigation_countdown_timer.sv | 153 +++++++++++++++
 tb/tb_irrigation_countdown_timer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/irrigation_countdown_timer_pkg.sv
// rtl/irrigation_countdown_timer_pkg.sv - shared state, BCD limits and digit widths for the irrigation timer
package irrigation_timer_pkg;

    typedef enum logic {
        COUNTING = 1'b0,
        EXPIRED  = 1'b1
    } timer_state_t;

    // Largest value each BCD digit position may hold
    localparam int SEC_D_MAX = 5;
    localparam int DIGIT_MAX = 9;
    localparam int MIN_D_MAX = 3;

    // Digit widths, also used by the timer reset logic for zero detection
    localparam int MIN_D_W = 2;
    localparam int MIN_U_W = 4;
    localparam int SEC_D_W = 3;
    localparam int SEC_U_W = 4;

    // Largest preset that fits the minutes digits
    localparam int PRESET_MINUTES_MAX = 39;

endpackage

// File: rtl/irrigation_countdown_timer_if.sv
// rtl/irrigation_countdown_timer_if.sv - mode select and MM:SS digit/status bundle of the irrigation timer
interface irrigation_countdown_timer_if;
    import irrigation_timer_pkg::*;

    logic               splinker_mode_on;
    logic [MIN_D_W-1:0] minutes_d;
    logic [MIN_U_W-1:0] minutes_u;
    logic [SEC_D_W-1:0] seconds_d;
    logic [SEC_U_W-1:0] seconds_u;
    logic               second_tick;
    logic               expired;

    // Master selects the mode and observes the count
    modport master (
        output splinker_mode_on,
        input  minutes_d,
        input  minutes_u,
        input  seconds_d,
        input  seconds_u,
        input  second_tick,
        input  expired
    );

    // Slave is the timer itself
    modport slave (
        input  splinker_mode_on,
        output minutes_d,
        output minutes_u,
        output seconds_d,
        output seconds_u,
        output second_tick,
        output expired
    );

endinterface

// File: rtl/irrigation_countdown_timer_bcd_down_digit.sv
// rtl/irrigation_countdown_timer_bcd_down_digit.sv - one BCD down-counting digit with borrow in/out
module bcd_down_digit #(
    parameter int WIDTH     = 4,
    parameter int MAX_VALUE = 9
) (
    input  logic             clock,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec_en,
    input  logic             borrow_in,
    output logic [WIDTH-1:0] digit,
    output logic             borrow_out
);

    // A digit at zero passes the borrow on to the next more significant digit
    assign borrow_out = borrow_in && (digit == '0);

    // Load wins; otherwise step down when this digit is reached by the borrow chain
    always_ff @(posedge clock) begin
        if (load) begin
            digit <= load_value;
        end else if (dec_en && borrow_in) begin
            if (digit == '0) begin
                digit <= WIDTH'(MAX_VALUE);
            end else begin
                digit <= digit - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/irrigation_countdown_timer.sv
// rtl/irrigation_countdown_timer.sv - per-mode MM:SS BCD countdown with one-second prescaler and expiry flag
module irrigation_countdown_timer
    import irrigation_timer_pkg::*;
#(
    parameter int CLOCKS_PER_SECOND = 50_000_000,
    parameter int SPRINKLER_MINUTES = 5,
    parameter int DRIP_MINUTES      = 15
) (
    input  logic                       clock,
    input  logic                       reset,
    irrigation_countdown_timer_if.slave bus
);

    // Out-of-range parameters stop elaboration
    generate
        if (CLOCKS_PER_SECOND < 1) begin : g_bad_cps
            $error("irrigation_countdown_timer: CLOCKS_PER_SECOND must be at least 1");
        end
        if (SPRINKLER_MINUTES < 0 || SPRINKLER_MINUTES > PRESET_MINUTES_MAX) begin : g_bad_spr
            $error("irrigation_countdown_timer: SPRINKLER_MINUTES must be within 0..39");
        end
        if (DRIP_MINUTES < 0 || DRIP_MINUTES > PRESET_MINUTES_MAX) begin : g_bad_drip
            $error("irrigation_countdown_timer: DRIP_MINUTES must be within 0..39");
        end
    endgenerate

    localparam int PRESC_W = (CLOCKS_PER_SECOND > 1) ? $clog2(CLOCKS_PER_SECOND) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLOCKS_PER_SECOND - 1);

    // Presets split into BCD digits at elaboration time
    localparam logic [MIN_D_W-1:0] SPR_MIN_D  = MIN_D_W'(SPRINKLER_MINUTES / 10);
    localparam logic [MIN_U_W-1:0] SPR_MIN_U  = MIN_U_W'(SPRINKLER_MINUTES % 10);
    localparam logic [MIN_D_W-1:0] DRIP_MIN_D = MIN_D_W'(DRIP_MINUTES / 10);
    localparam logic [MIN_U_W-1:0] DRIP_MIN_U = MIN_U_W'(DRIP_MINUTES % 10);

    timer_state_t       state;
    logic [PRESC_W-1:0] prescaler;
    logic               second_tick_q;
    logic               expired_q;

    logic [MIN_D_W-1:0] min_d;
    logic [MIN_U_W-1:0] min_u;
    logic [SEC_D_W-1:0] sec_d;
    logic [SEC_U_W-1:0] sec_u;
    logic [MIN_D_W-1:0] load_min_d;
    logic [MIN_U_W-1:0] load_min_u;

    logic borrow_sec_u;
    logic borrow_sec_d;
    logic borrow_min_u;
    logic at_zero;
    logic at_one;
    logic terminal;
    logic dec_en;

    assign load_min_d = bus.splinker_mode_on ? SPR_MIN_D : DRIP_MIN_D;
    assign load_min_u = bus.splinker_mode_on ? SPR_MIN_U : DRIP_MIN_U;

    assign terminal = (prescaler == PRESC_LAST);
    assign at_one   = (min_d == '0) && (min_u == '0) && (sec_d == '0) && (sec_u == SEC_U_W'(1));

    // Digits move only on a counting terminal edge that reset does not override
    assign dec_en = !reset && (state == COUNTING) && terminal && !at_zero;

    bcd_down_digit #(.WIDTH(SEC_U_W), .MAX_VALUE(DIGIT_MAX)) u_sec_u (
        .clock      (clock),
        .load       (reset),
        .load_value (SEC_U_W'(0)),
        .dec_en     (dec_en),
        .borrow_in  (1'b1),
        .digit      (sec_u),
        .borrow_out (borrow_sec_u)
    );

    bcd_down_digit #(.WIDTH(SEC_D_W), .MAX_VALUE(SEC_D_MAX)) u_sec_d (
        .clock      (clock),
        .load       (reset),
        .load_value (SEC_D_W'(0)),
        .dec_en     (dec_en),
        .borrow_in  (borrow_sec_u),
        .digit      (sec_d),
        .borrow_out (borrow_sec_d)
    );

    bcd_down_digit #(.WIDTH(MIN_U_W), .MAX_VALUE(DIGIT_MAX)) u_min_u (
        .clock      (clock),
        .load       (reset),
        .load_value (load_min_u),
        .dec_en     (dec_en),
        .borrow_in  (borrow_sec_d),
        .digit      (min_u),
        .borrow_out (borrow_min_u)
    );

    // A borrow out of the top digit means every digit is zero
    bcd_down_digit #(.WIDTH(MIN_D_W), .MAX_VALUE(MIN_D_MAX)) u_min_d (
        .clock      (clock),
        .load       (reset),
        .load_value (load_min_d),
        .dec_en     (dec_en),
        .borrow_in  (borrow_min_u),
        .digit      (min_d),
        .borrow_out (at_zero)
    );

    // Control FSM: prescaler, tick pulse and expiry with registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= COUNTING;
            prescaler     <= '0;
            second_tick_q <= 1'b0;
            expired_q     <= 1'b0;
        end else begin
            case (state)
                COUNTING: begin
                    if (at_zero) begin
                        // Zero preset: nothing to count, expire right away
                        state         <= EXPIRED;
                        second_tick_q <= 1'b0;
                        expired_q     <= 1'b1;
                    end else if (terminal) begin
                        prescaler     <= '0;
                        second_tick_q <= 1'b1;
                        if (at_one) begin
                            state     <= EXPIRED;
                            expired_q <= 1'b1;
                        end
                    end else begin
                        prescaler     <= prescaler + PRESC_W'(1);
                        second_tick_q <= 1'b0;
                    end
                end
                EXPIRED: begin
                    second_tick_q <= 1'b0;
                    expired_q     <= 1'b1;
                end
                default: begin
                    state         <= COUNTING;
                    second_tick_q <= 1'b0;
                    expired_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.minutes_d   = min_d;
    assign bus.minutes_u   = min_u;
    assign bus.seconds_d   = sec_d;
    assign bus.seconds_u   = sec_u;
    assign bus.second_tick = second_tick_q;
    assign bus.expired     = expired_q;

endmodule

// File: tb/tb_irrigation_countdown_timer.sv
// tb/tb_irrigation_countdown_timer.sv - randomized model-checked bench for irrigation_countdown_timer
module tb_irrigation_countdown_timer;

    localparam int CPS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a  = 1'b1;
    logic rst_b  = 1'b1;
    logic mode_a = 1'b1;
    logic mode_b = 1'b1;
    bit   cmp_en = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    irrigation_countdown_timer_if if_a ();
    irrigation_countdown_timer_if if_b ();

    assign if_a.splinker_mode_on = mode_a;
    assign if_b.splinker_mode_on = mode_b;

    irrigation_countdown_timer #(
        .CLOCKS_PER_SECOND (CPS),
        .SPRINKLER_MINUTES (5),
        .DRIP_MINUTES      (10)
    ) dut_a (
        .clock (clk),
        .reset (rst_a),
        .bus   (if_a)
    );

    irrigation_countdown_timer #(
        .CLOCKS_PER_SECOND (CPS),
        .SPRINKLER_MINUTES (1),
        .DRIP_MINUTES      (0)
    ) dut_b (
        .clock (clk),
        .reset (rst_b),
        .bus   (if_b)
    );

    logic [15:0] bcd_a;
    logic [15:0] bcd_b;
    assign bcd_a = {2'b00, if_a.minutes_d, if_a.minutes_u, 1'b0, if_a.seconds_d, if_a.seconds_u};
    assign bcd_b = {2'b00, if_b.minutes_d, if_b.minutes_u, 1'b0, if_b.seconds_d, if_b.seconds_u};

    // Reference model: remaining seconds, cycles into the current second, flags
    int spr_min [2] = '{5, 1};
    int drip_min[2] = '{10, 0};
    int m_rem   [2];
    int m_phase [2];
    bit m_exp   [2];
    bit m_tick  [2];

    function automatic int to_bcd(input int rem);
        int m;
        int s;
        m = rem / 60;
        s = rem % 60;
        return ((m / 10) << 12) | ((m % 10) << 8) | ((s / 10) << 4) | (s % 10);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on each rising edge from the same inputs the DUTs see
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic r;
            logic md;
            r  = (k == 0) ? rst_a : rst_b;
            md = (k == 0) ? mode_a : mode_b;
            if (r) begin
                m_rem[k]   = 60 * (md ? spr_min[k] : drip_min[k]);
                m_phase[k] = 0;
                m_exp[k]   = 1'b0;
                m_tick[k]  = 1'b0;
            end else if (m_exp[k]) begin
                m_tick[k] = 1'b0;
            end else if (m_rem[k] == 0) begin
                m_exp[k]  = 1'b1;
                m_tick[k] = 1'b0;
            end else begin
                m_phase[k] = m_phase[k] + 1;
                m_tick[k]  = 1'b0;
                if (m_phase[k] == CPS) begin
                    m_phase[k] = 0;
                    m_rem[k]   = m_rem[k] - 1;
                    m_tick[k]  = 1'b1;
                    if (m_rem[k] == 0) m_exp[k] = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_digits_a", bcd_a, to_bcd(m_rem[0]));
            check("model_tick_a", if_a.second_tick, m_tick[0]);
            check("model_expired_a", if_a.expired, m_exp[0]);
            check("model_digits_b", bcd_b, to_bcd(m_rem[1]));
            check("model_tick_b", if_b.second_tick, m_tick[1]);
            check("model_expired_b", if_b.expired, m_exp[1]);
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        check("reset_load_a", bcd_a, 16'h0500);
        check("reset_tick_a", if_a.second_tick, 0);
        check("reset_expired_a", if_a.expired, 0);
        check("reset_load_b", bcd_b, 16'h0100);

        // Release both; A counts from 05:00, B from 01:00
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_first_dec_a", bcd_a, 16'h0500);
        check("pre_first_tick_a", if_a.second_tick, 0);
        @(negedge clk);
        check("first_dec_a", bcd_a, 16'h0459);
        check("first_tick_a", if_a.second_tick, 1);
        @(negedge clk);
        check("tick_one_cycle_a", if_a.second_tick, 0);
        mode_a = 1'b0;

        repeat (234) @(negedge clk);
        check("b_one_left", bcd_b, 16'h0001);
        check("b_not_expired", if_b.expired, 0);
        @(negedge clk);
        check("b_expiry_digits", bcd_b, 16'h0000);
        check("b_expired_240", if_b.expired, 1);
        check("a_at_240", bcd_a, 16'h0400);
        repeat (20) @(negedge clk);
        check("b_hold_digits", bcd_b, 16'h0000);
        check("b_hold_expired", if_b.expired, 1);

        // Reset lands on the terminal-count edge while A shows 03:27
        repeat (115) @(negedge clk);
        check("a_at_0327", bcd_a, 16'h0327);
        rst_a  = 1'b1;
        mode_a = 1'b1;
        @(negedge clk);
        check("mid_reset_digits", bcd_a, 16'h0500);
        check("mid_reset_no_tick", if_a.second_tick, 0);
        rst_a = 1'b0;
        repeat (3) @(negedge clk);
        check("restart_full_period", bcd_a, 16'h0500);
        @(negedge clk);
        check("restart_dec", bcd_a, 16'h0459);

        // Mode follows while reset is held
        rst_a  = 1'b1;
        mode_a = 1'b0;
        @(negedge clk);
        check("held_mode_drip", bcd_a, 16'h1000);
        mode_a = 1'b1;
        @(negedge clk);
        check("held_mode_spr", bcd_a, 16'h0500);
        mode_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b0;
        repeat (4) @(negedge clk);
        check("borrow_0959", bcd_a, 16'h0959);
        repeat (240) @(negedge clk);
        check("borrow_0859", bcd_a, 16'h0859);

        // Zero preset on B
        rst_b  = 1'b1;
        mode_b = 1'b0;
        @(negedge clk);
        check("zero_load", bcd_b, 16'h0000);
        check("zero_reset_expired", if_b.expired, 0);
        rst_b = 1'b0;
        @(negedge clk);
        check("zero_expired_next", if_b.expired, 1);
        check("zero_no_tick", if_b.second_tick, 0);
        repeat (10) @(negedge clk);
        check("zero_hold", bcd_b, 16'h0000);

        // Random mode toggles and occasional reset pulses
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) mode_a = ~mode_a;
            if ($urandom_range(0, 7) == 0) mode_b = ~mode_b;
            rst_a = ($urandom_range(0, 299) == 0);
            rst_b = ($urandom_range(0, 149) == 0);
        end

        // Let A run to expiry from the sprinkler preset
        @(negedge clk);
        rst_a  = 1'b1;
        mode_a = 1'b1;
        rst_b  = 1'b0;
        @(negedge clk);
        rst_a = 1'b0;
        for (int i = 0; i < 1230; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) mode_a = ~mode_a;
        end
        check("a_final_expired", if_a.expired, 1);
        check("a_final_digits", bcd_a, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
